mem_responder: RTL and testbench
================================

# mem_responder

Word-organised memory responder that serves load/store and fetch requests issued by the CPU over a valid/ready request channel and a valid/ready response channel. It answers each accepted request after a fixed, parameterised latency, applies byte-enable writes, and flags out-of-range accesses. It is the slave end of the CPU's memory port and replaces the always-enabled zero-latency memory path.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2: cycles from the request-accept cycle to the first rsp_valid cycle; legal values ≥1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE and while rst is low.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[31:2].
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  response present; held until taken.
- rsp_ready  input  1  CPU takes the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access faulted; no memory change.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, accept:
  - Error if req_addr[31:2] ≥ DEPTH_WORDS, or if the alignment check below flags the access.
  - No error, store: write enabled bytes at the accept edge. Bytes with be=0 are unchanged. rdata register = 0.
  - No error, load: rdata register = full word. req_be is ignored.
  - Error: no write; rdata register = 0; err register = 1.
  - Next state: RESP if LATENCY==1; otherwise BUSY with the counter loaded with LATENCY-2.
- BUSY: while the counter is non-zero, decrement it. At 0, go to RESP.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are driven from the registers and stay stable. When rsp_ready=1, go to IDLE. Otherwise hold.
- Exactly one transaction is outstanding. Requests in BUSY/RESP are not accepted; req_valid is ignored there.
- Memory array is not reset. Contents survive rst.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready=0 while rst is high, and 1 in the first cycle after release.
- Request accepted in cycle n produces rsp_valid=1 first in cycle n+LATENCY.
- Throughput with rsp_ready tied high is one transaction per LATENCY+1 cycles, because the IDLE cycle is mandatory.
- Write commits at the accept edge. A load accepted later returns the new data.
- Backpressure: rsp_valid, rsp_rdata and rsp_err are held unchanged for any number of rsp_ready=0 cycles.
- Reset mid-transaction: the responder returns to IDLE at once and the pending response is dropped. A write that was already accepted remains committed.
- Address wrap: no wrap. Any index ≥ DEPTH_WORDS is an error, including 0xFFFFFFFC.

## Configuration
- MEM_ALIGN_CHECK_EN defined: req_addr[1:0]≠0 gives rsp_err=1, with no write and rdata=0.
- MEM_ALIGN_CHECK_EN undefined: req_addr[1:0] is ignored and the access uses word req_addr[31:2].

## Test plan
- **Reset:** assert rst mid-BUSY → the cycle after the asynchronous assert shows rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0. After release, req_ready=1 and no stale response appears.
- **Store then load:** with LATENCY=2, store 0xDEADBEEF, be=4'hF, to 0x10. Then store 0x000000AA, be=4'b0001, to 0x10. Then load 0x10 → rsp_rdata=0xDEADBEAA, rsp_err=0. Each rsp_valid appears exactly 2 cycles after accept.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_rdata stay stable and req_ready=0 throughout. A raised req_valid during this time is not accepted.
- **Range:** load 4*DEPTH_WORDS → rsp_err=1, rsp_rdata=0. Store to the same address → rsp_err=1, and a subsequent load of word 0 is unchanged.
- **Alignment:** load 0x12 with MEM_ALIGN_CHECK_EN → rsp_err=1. Without the macro → data of word 0x10, rsp_err=0.
- **LATENCY=1 back-to-back:** with rsp_ready tied high, 4 loads are accepted in cycles 0, 2, 4, 6 and rsp_valid is seen in cycles 1, 3, 5, 7.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Word-organised memory slave answering one valid/ready request at
//             a time after LATENCY cycles, with byte-enable stores and range
//             faults. Optional macro MEM_ALIGN_CHECK_EN faults misaligned
//             addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] C_CNT_LOAD = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    data_q;
   logic           err_q;
   logic           rsp_valid_q;
   logic [31:0]    rsp_rdata_q;
   logic           rsp_err_q;
   logic [31:0]    mem_q [DEPTH_WORDS];

   logic           w_accept;
   logic           w_in_range;
   logic           w_misaligned;
   logic           w_err;
   logic [AW-1:0]  w_idx;
   logic [31:0]    w_rdata;

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign w_accept   = req_valid && req_ready;
   // Full 30-bit index is compared so high addresses never alias onto the array.
   assign w_in_range = ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
   assign w_idx      = req_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = (req_addr[1:0] != 2'b00);
`else
   logic w_unused_lsb;
   assign w_unused_lsb = &{1'b0, req_addr[1:0]};
   assign w_misaligned = 1'b0;
`endif

   assign w_err   = !w_in_range || w_misaligned;
   assign w_rdata = (!w_err && !req_wr) ? mem_q[w_idx] : 32'h0;

   always_ff @(posedge clk) begin
      if (w_accept && req_wr && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
               mem_q[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         data_q      <= 32'h0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  if (LATENCY == 1) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= w_rdata;
                     rsp_err_q   <= w_err;
                  end else begin
                     state_q <= S_BUSY;
                     cnt_q   <= C_CNT_LOAD;
                     data_q  <= w_rdata;
                     err_q   <= w_err;
                  end
               end
            end
            S_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= data_q;
                  rsp_err_q   <= err_q;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 32'h0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder (LATENCY=2 main instance,
//             LATENCY=1 instance for back-to-back throughput).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid1 = 1'b0, req_wr1 = 1'b0;
   logic [31:0] req_addr1 = '0, req_wdata1 = '0;
   logic [3:0]  req_be1 = '0;
   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_rdata1;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
      .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
      .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
      .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: applies the access to the array model, returns the response.
   task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic e);
      int unsigned idx;
      idx = addr >> 2;
      e   = (idx >= DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) e = 1'b1;
`endif
      rd = 32'h0;
      if (!e) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            rd = ref_mem[idx];
         end
      end
   endtask

   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input logic poke,
                      output logic [31:0] rd_o, output logic err_o);
      logic [31:0] er;
      logic        ee;
      int          lat;
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      model(wr, addr, wdata, be, er, ee);
      @(posedge clk);
      @(negedge clk);
      if (poke) begin
         // A store presented while busy must be ignored entirely.
         req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0;
         req_wdata = $urandom; req_be = 4'hF;
      end else begin
         req_valid = 1'b0;
      end
      lat = 1;
      while (rsp_valid !== 1'b1 && lat <= LAT + 4) begin
         chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, LAT);
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, er);
         chk("hold_err", {31'b0, rsp_err}, {31'b0, ee});
         chk("hold_ready", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_rdata", rsp_rdata, er);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, ee});
      rd_o = rsp_rdata; err_o = rsp_err;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("after_take_valid", {31'b0, rsp_valid}, 32'd0);
      chk("after_take_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a, w, pat [4];
      logic        e;
      int          j, mode;

      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < DEPTH; i++) txn(1'b1, i * 4, $urandom, 4'hF, 0, 1'b0, rd, e);

      // Directed store/merge/load
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, e);
      txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0, rd, e);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, e);
      chk("merge_rdata", rd, 32'hDEADBEAA);
      chk("merge_err", {31'b0, e}, 32'd0);

      // Backpressure with an ignored request
      txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, e);
      txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, e);

      // Range faults
      txn(1'b0, 4 * DEPTH, 32'h0, 4'hF, 0, 1'b0, rd, e);
      chk("range_ld_err", {31'b0, e}, 32'd1);
      chk("range_ld_rdata", rd, 32'd0);
      txn(1'b1, 4 * DEPTH, 32'hFFFF_FFFF, 4'hF, 1, 1'b0, rd, e);
      chk("range_st_err", {31'b0, e}, 32'd1);
      txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 1'b0, rd, e);
      chk("range_top_err", {31'b0, e}, 32'd1);
      txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, e);

      // Alignment
      txn(1'b0, 32'h12, 32'h0, 4'h0, 0, 1'b0, rd, e);
`ifdef MEM_ALIGN_CHECK_EN
      chk("align_err", {31'b0, e}, 32'd1);
      chk("align_rdata", rd, 32'd0);
`else
      chk("align_rdata", rd, 32'hDEADBEAA);
      chk("align_err", {31'b0, e}, 32'd0);
`endif

      // Randomised traffic
      for (int i = 0; i < 60; i++) begin
         mode = $urandom_range(0, 9);
         if (mode < 8)       a = ($urandom_range(0, DEPTH - 1) * 4) | ((mode == 0) ? $urandom_range(1, 3) : 0);
         else if (mode == 8) a = 4 * DEPTH + ($urandom_range(0, 255) * 4);
         else                a = $urandom;
         txn($urandom_range(0, 1), a, $urandom, 4'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), rd, e);
      end

      // Reset in the middle of BUSY after a committed store
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
      model(1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_ready", {31'b0, req_ready}, 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      chk("midrst_err", {31'b0, rsp_err}, 32'd0);
      chk("midrst_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_stale_valid", {31'b0, rsp_valid}, 32'd0);
      end
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, e);
      chk("rst_commit", rd, 32'h1234_5678);

      // LATENCY=1 back-to-back: 4 stores then 4 loads, one every two cycles
      for (int i = 0; i < 4; i++) pat[i] = $urandom;
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         j = k / 2;
         if (k % 2 == 0) begin
            req_valid1 = 1'b1; req_wr1 = (j < 4); req_addr1 = (j % 4) * 4;
            req_wdata1 = pat[j % 4]; req_be1 = 4'hF;
         end
         chk("b2b_ready", {31'b0, req_ready1}, {31'b0, (k % 2 == 0)});
         chk("b2b_valid", {31'b0, rsp_valid1}, {31'b0, (k % 2 == 1)});
         if (k % 2 == 1) begin
            w = (j < 4) ? 32'h0 : pat[j % 4];
            chk("b2b_rdata", rsp_rdata1, w);
            chk("b2b_err", {31'b0, rsp_err1}, 32'd0);
         end
         @(negedge clk);
      end
      req_valid1 = 1'b0;
      chk("b2b_end_valid", {31'b0, rsp_valid1}, 32'd0);
      chk("b2b_end_ready", {31'b0, req_ready1}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
